// File: rtl/uart_rcv_controller.sv
// Sequencing FSM for the UART receive datapath: start-bit validation, mid-bit
// sampling strobes, stop-bit check, host valid/ack handshake and sticky errors.
module uart_rcv_controller #(
  parameter int word_size = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic ser_in_0,
  input  logic sc_eq_3,
  input  logic sc_lt_7,
  input  logic bc_eq_8,
  input  logic rx_ack,
  input  logic err_clr,
  output logic clr_sample_counter,
  output logic inc_sample_counter,
  output logic clr_bit_counter,
  output logic inc_bit_counter,
  output logic shift,
  output logic load,
  output logic rx_valid,
  output logic framing_err,
  output logic overrun_err,
  output logic busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RECV  = 2'd2;
  localparam logic [1:0] BREAK = 2'd3;

  // The word length reaches this block only through bc_eq_8; any other width
  // needs a datapath whose bit-count flag is retargeted to match.
  if (word_size != 8) begin : g_word_size_set_by_datapath
  end

  logic [1:0] state_q, state_d;
  logic       rx_valid_q, rx_valid_d;
  logic       framing_err_q, framing_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       busy_q, busy_d;
  logic       set_framing, set_overrun;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d            = state_q;
    clr_sample_counter = 1'b0;
    inc_sample_counter = 1'b0;
    clr_bit_counter    = 1'b0;
    inc_bit_counter    = 1'b0;
    shift              = 1'b0;
    load               = 1'b0;
    set_framing        = 1'b0;
    set_overrun        = 1'b0;

    if (rst) begin
      clr_sample_counter = 1'b1;
      clr_bit_counter    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr_sample_counter = 1'b1;
          clr_bit_counter    = 1'b1;
          if (sample_tick && ser_in_0) state_d = START;
        end

        START: begin
          if (sample_tick) begin
            if (!ser_in_0) begin
              clr_sample_counter = 1'b1;
              clr_bit_counter    = 1'b1;
              state_d            = IDLE;
            end else if (sc_eq_3) begin
              clr_sample_counter = 1'b1;
              state_d            = RECV;
            end else begin
              inc_sample_counter = 1'b1;
            end
          end
        end

        RECV: begin
          if (sample_tick) begin
            if (sc_lt_7) begin
              inc_sample_counter = 1'b1;
            end else if (!bc_eq_8) begin
              clr_sample_counter = 1'b1;
              shift              = 1'b1;
              inc_bit_counter    = 1'b1;
            end else begin
              // Stop-bit midpoint: an unconsumed word is never overwritten.
              clr_sample_counter = 1'b1;
              clr_bit_counter    = 1'b1;
              if (ser_in_0) begin
                set_framing = 1'b1;
                state_d     = BREAK;
              end else if (!rx_valid_q || rx_ack) begin
                load    = 1'b1;
                state_d = IDLE;
              end else begin
                set_overrun = 1'b1;
                state_d     = IDLE;
              end
            end
          end
        end

        BREAK: begin
          if (sample_tick && !ser_in_0) begin
            state_d = IDLE;
          end else begin
            clr_sample_counter = 1'b1;
            clr_bit_counter    = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    if (load)        rx_valid_d = 1'b1;
    else if (rx_ack) rx_valid_d = 1'b0;
    else             rx_valid_d = rx_valid_q;

    framing_err_d = set_framing | (framing_err_q & ~err_clr);
    overrun_err_d = set_overrun | (overrun_err_q & ~err_clr);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rcv_controller.sv
// Bench for uart_rcv_controller: behavioural datapath around the FSM, a load
// scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_uart_rcv_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sample_tick, ser_in_0, sc_eq_3, sc_lt_7, bc_eq_8, rx_ack, err_clr;
  logic clr_sample_counter, inc_sample_counter, clr_bit_counter, inc_bit_counter;
  logic shift, load, rx_valid, framing_err, overrun_err, busy;

  uart_rcv_controller #(.word_size(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .sample_tick        (sample_tick),
    .ser_in_0           (ser_in_0),
    .sc_eq_3            (sc_eq_3),
    .sc_lt_7            (sc_lt_7),
    .bc_eq_8            (bc_eq_8),
    .rx_ack             (rx_ack),
    .err_clr            (err_clr),
    .clr_sample_counter (clr_sample_counter),
    .inc_sample_counter (inc_sample_counter),
    .clr_bit_counter    (clr_bit_counter),
    .inc_bit_counter    (inc_bit_counter),
    .shift              (shift),
    .load               (load),
    .rx_valid           (rx_valid),
    .framing_err        (framing_err),
    .overrun_err        (overrun_err),
    .busy               (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tick_div = 1;
  int div_cnt  = 0;
  always @(posedge clk) div_cnt <= (div_cnt >= tick_div - 1) ? 0 : div_cnt + 1;
  assign sample_tick = (div_cnt == 0);

  logic line;
  assign ser_in_0 = ~line;

  // Datapath model: counters, LSB-first shift register, data register.
  logic [3:0] sc, bc;
  logic [7:0] shreg, dreg;
  assign sc_eq_3 = (sc == 4'd3);
  assign sc_lt_7 = (sc < 4'd7);
  assign bc_eq_8 = (bc == 4'd8);
  always @(posedge clk) begin
    if (clr_sample_counter)      sc <= 4'd0;
    else if (inc_sample_counter) sc <= sc + 4'd1;
    if (clr_bit_counter)         bc <= 4'd0;
    else if (inc_bit_counter)    bc <= bc + 4'd1;
    if (shift) shreg <= {~ser_in_0, shreg[7:1]};
    if (load)  dreg  <= shreg;
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  int   shift_cyc_q[$];
  int   shift_cnt  = 0;
  int   valid_rise = -1;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_load: load at cycle %0d with no frame expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_cycle", cyc, e.at);
        check("load_data", shreg, e.data);
        check("shift_count", shift_cnt, 8);
      end
    end
    if (clr_bit_counter === 1'b1) shift_cnt = 0;
    if (shift === 1'b1) begin
      shift_cnt++;
      shift_cyc_q.push_back(cyc);
    end
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) valid_rise = cyc;
    valid_prev = rx_valid;
  end

  // Drives one 10-bit frame, each bit 8*tick_div cycles; returns the first
  // tick cycle that sees the line low.
  task automatic drive_frame(input logic [7:0] data, input bit stop_ok,
                             input bit expect_load, input bit ack_at_load,
                             output int t0);
    bit found;
    int n;
    found = 1'b0;
    n     = tick_div;
    t0    = -1;
    for (int k = 0; k < 80 * n; k++) begin
      int idx;
      idx = k / (8 * n);
      if (idx == 0)      line = 1'b0;
      else if (idx <= 8) line = data[idx-1];
      else               line = stop_ok;
      if (!found && sample_tick) begin
        exp_t e;
        found = 1'b1;
        t0    = cyc;
        if (expect_load) begin
          e.data = data;
          e.at   = cyc + 76 * n;
          exp_q.push_back(e);
        end
      end
      rx_ack = found && ack_at_load && (cyc == t0 + 76 * n);
      @(negedge clk);
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    rst     = 1'b1;
    line    = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;

    // Reset state and strobes during reset.
    @(negedge clk);
    check("rst_clr_sc", clr_sample_counter, 1);
    check("rst_clr_bc", clr_bit_counter, 1);
    check("rst_inc_sc", inc_sample_counter, 0);
    check("rst_shift", shift, 0);
    check("rst_load", load, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_framing", framing_err, 0);
    check("rst_overrun", overrun_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Frame 0xA5 at full tick rate: shift timing and rx_valid rise.
    shift_cyc_q.delete();
    drive_frame(8'hA5, 1'b1, 1'b1, 1'b0, t0);
    check("a5_shift_pulses", shift_cyc_q.size(), 8);
    if (shift_cyc_q.size() == 8)
      for (int i = 0; i < 8; i++) check("a5_shift_cycle", shift_cyc_q[i], t0 + 12 + 8 * i);
    check("a5_valid_rise", valid_rise, t0 + 77);
    check("a5_dreg", dreg, 8'hA5);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ack_clears_valid", rx_valid, 0);
    check("a5_framing", framing_err, 0);
    check("a5_overrun", overrun_err, 0);

    // Start glitch: two low ticks then high.
    repeat (3) @(negedge clk);
    shift_cyc_q.delete();
    line = 1'b0;
    @(negedge clk);
    check("glitch_busy_start", busy, 1);
    @(negedge clk);
    line = 1'b1;
    @(negedge clk);
    check("glitch_busy_idle", busy, 0);
    repeat (4) @(negedge clk);
    check("glitch_no_shift", shift_cyc_q.size(), 0);

    // Bad stop bit: BREAK holds while the line stays low.
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("break_busy", busy, 1);
    check("break_framing", framing_err, 1);
    check("break_rx_valid", rx_valid, 0);
    line = 1'b1;
    @(negedge clk);
    check("break_exit_busy", busy, 0);
    check("framing_sticky", framing_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("framing_cleared", framing_err, 0);

    // Back-to-back frames without ack: overrun keeps the first word.
    repeat (2) @(negedge clk);
    drive_frame(8'h3C, 1'b1, 1'b1, 1'b0, t0);
    drive_frame(8'hC3, 1'b1, 1'b0, 1'b0, t0);
    check("overrun_set", overrun_err, 1);
    check("overrun_dreg", dreg, 8'h3C);
    check("overrun_valid", rx_valid, 1);
    check("overrun_no_framing", framing_err, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("overrun_cleared", overrun_err, 0);

    // Same situation, but ack arrives in the completion cycle.
    drive_frame(8'h99, 1'b1, 1'b1, 1'b1, t0);
    check("ack_load_valid", rx_valid, 1);
    check("ack_load_overrun", overrun_err, 0);
    check("ack_load_dreg", dreg, 8'h99);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;

    // Tick every 4th cycle, misaligned start.
    tick_div = 4;
    repeat (3) @(negedge clk);
    drive_frame(8'h01, 1'b1, 1'b1, 1'b0, t0);
    check("div4_valid_rise", valid_rise, t0 + 4 * 76 + 1);
    check("div4_dreg", dreg, 8'h01);
    tick_div = 1;
    repeat (4) @(negedge clk);

    // Reset 40 cycles into a frame, then a clean frame.
    line = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      d = 8'hC6;
      if (k >= 8) line = d[k/8 - 1];
      @(negedge clk);
    end
    check("midrst_busy_before", busy, 1);
    rst  = 1'b1;
    line = 1'b1;
    #1;
    check("midrst_clr_sc", clr_sample_counter, 1);
    check("midrst_clr_bc", clr_bit_counter, 1);
    check("midrst_inc_sc", inc_sample_counter, 0);
    check("midrst_inc_bc", inc_bit_counter, 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_framing", framing_err, 0);
    check("midrst_overrun", overrun_err, 0);
    repeat (3) @(negedge clk);
    drive_frame(8'h5A, 1'b1, 1'b1, 1'b0, t0);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_dreg", dreg, 8'h5A);
    check("post_rst_errors", {framing_err, overrun_err}, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
